// File: rtl/reset_sync_sequencer.sv
// rtl/reset_sync_sequencer.sv - async-assert, sync-release reset with stretch and staggered multi-output release
module reset_sync_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int STRETCH_CYCLES = 4,
    parameter int NUM_OUT        = 3,
    parameter int STAGGER        = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sw_rst_req,
    output logic [NUM_OUT-1:0] rst_n_out,
    output logic               rst_done,
    output logic               busy
);

    localparam int CNT_MAX = (STRETCH_CYCLES > STAGGER) ? STRETCH_CYCLES : STAGGER;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER - 1);

    typedef enum logic [1:0] {
        S_ASSERT,
        S_STRETCH,
        S_STAGGER,
        S_DONE
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                 rst_sync;
    logic                 sync_rising;
    logic [NUM_OUT-1:0]   rel_next;
    logic [CNT_W-1:0]     cnt_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync = sync_q[SYNC_STAGES-1];
    // Looking one stage early lets the FSM leave ASSERT on the same edge rst_sync rises.
    assign sync_rising = sync_q[SYNC_STAGES-2];

    assign rel_next = NUM_OUT'({rst_n_out, 1'b1});
    assign cnt_last = (state == S_STRETCH) ? STRETCH_LAST : STAGGER_LAST;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_ASSERT;
            cnt       <= '0;
            rst_n_out <= '0;
            rst_done  <= 1'b0;
            busy      <= 1'b0;
        end else if (sw_rst_req && rst_sync) begin
            state     <= S_STRETCH;
            cnt       <= '0;
            rst_n_out <= '0;
            rst_done  <= 1'b0;
            busy      <= 1'b1;
        end else begin
            case (state)
                S_ASSERT: begin
                    if (sync_rising) begin
                        state <= S_STRETCH;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                S_STRETCH, S_STAGGER: begin
                    if (cnt == cnt_last) begin
                        cnt       <= '0;
                        rst_n_out <= rel_next;
                        if (rel_next[NUM_OUT-1]) begin
                            state    <= S_DONE;
                            rst_done <= 1'b1;
                            busy     <= 1'b0;
                        end else begin
                            state <= S_STAGGER;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state <= S_DONE;
                end
                default: begin
                    state <= S_ASSERT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sync_sequencer.sv
// tb/tb_reset_sync_sequencer.sv - self-checking bench for reset_sync_sequencer
`timescale 1us/100ns
module tb_reset_sync_sequencer;

    localparam int S   = 2;
    localparam int ST  = 4;
    localparam int NO  = 3;
    localparam int SG  = 2;
    localparam int BIG = 1 << 20;

    logic       clk = 1'b0;
    logic       rst_a, sw_a, rst_b, sw_b;
    logic [2:0] out_a;
    logic       done_a, busy_a;
    logic [0:0] out_b;
    logic       done_b, busy_b;

    int checks = 0;
    int passes = 0;
    int cyc = 0;

    // Reference model: absolute edge numbers of the sequence milestones.
    int pend = 1;
    int sync_edge = BIG;
    int busy_start = BIG;
    int rel0 = BIG;
    logic [2:0] exp_out;
    logic       exp_done, exp_busy;

    reset_sync_sequencer #(
        .SYNC_STAGES(S), .STRETCH_CYCLES(ST), .NUM_OUT(NO), .STAGGER(SG)
    ) dut_a (
        .clk(clk), .rst(rst_a), .sw_rst_req(sw_a),
        .rst_n_out(out_a), .rst_done(done_a), .busy(busy_a)
    );

    reset_sync_sequencer #(
        .SYNC_STAGES(3), .STRETCH_CYCLES(1), .NUM_OUT(1), .STAGGER(1)
    ) dut_b (
        .clk(clk), .rst(rst_b), .sw_rst_req(sw_b),
        .rst_n_out(out_b), .rst_done(done_b), .busy(busy_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic model_eval();
        for (int k = 0; k < NO; k++) exp_out[k] = (cyc >= rel0 + k * SG);
        exp_done = (cyc >= rel0 + (NO - 1) * SG);
        exp_busy = (cyc >= busy_start) && !exp_done;
    endtask

    task automatic model_async_rst();
        pend = 1; sync_edge = BIG; busy_start = BIG; rel0 = BIG;
        model_eval();
    endtask

    task automatic model_edge();
        if (!rst_a) begin
            pend = 1; sync_edge = BIG; busy_start = BIG; rel0 = BIG;
        end else if (pend == 1) begin
            pend = 0;
            sync_edge = cyc + S - 1;
            busy_start = sync_edge;
            rel0 = sync_edge + ST;
        end else if (sw_a && cyc > sync_edge) begin
            busy_start = cyc;
            rel0 = cyc + ST;
        end
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({out_a, done_a, busy_a} !== 5'b0) $display("FAIL reset_a got=%b want=00000", {out_a, done_a, busy_a});
        else passes++;
        checks++;
        if ({out_b, done_b, busy_b} !== 3'b0) $display("FAIL reset_b got=%b want=000", {out_b, done_b, busy_b});
        else passes++;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({out_a, done_a, busy_a} !== 5'b0) $display("FAIL reset_hold cyc=%0d got=%b want=00000", cyc, {out_a, done_a, busy_a});
            else passes++;
        end
    endtask

    task automatic test_power_on();
        int e1;
        #2 rst_a = 1'b1;
        e1 = cyc + 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if ({out_a, done_a, busy_a} !== {exp_out, exp_done, exp_busy})
                $display("FAIL power_on E%0d got=%b want=%b", cyc - e1 + 1, {out_a, done_a, busy_a}, {exp_out, exp_done, exp_busy});
            else passes++;
        end
        checks++;
        if (out_a !== 3'b111 || rel0 != e1 + 5) $display("FAIL power_on_final got=%b want=111", out_a);
        else passes++;
    endtask

    task automatic test_sw_pulse();
        int idle = $urandom_range(0, 3);
        for (int i = 0; i < idle; i++) tick();
        sw_a = 1'b1;
        tick();
        sw_a = 1'b0;
        for (int i = 0; i < 11; i++) begin
            checks++;
            if ({out_a, done_a, busy_a} !== {exp_out, exp_done, exp_busy})
                $display("FAIL sw_pulse cyc=%0d got=%b want=%b", cyc, {out_a, done_a, busy_a}, {exp_out, exp_done, exp_busy});
            else passes++;
            tick();
        end
    endtask

    task automatic test_async_mid();
        bit found = 0;
        sw_a = 1'b1;
        tick();
        sw_a = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            checks++;
            if ({out_a, done_a, busy_a} !== {exp_out, exp_done, exp_busy})
                $display("FAIL async_pre cyc=%0d got=%b want=%b", cyc, {out_a, done_a, busy_a}, {exp_out, exp_done, exp_busy});
            else passes++;
            if (exp_out == 3'b011) found = 1;
        end
        checks++;
        if (!found) $display("FAIL async_reach_011 got=%b want=011", out_a);
        else passes++;
        #($urandom_range(1, 2));
        rst_a = 1'b0;
        model_async_rst();
        #1;
        checks++;
        if ({out_a, done_a, busy_a} !== 5'b0) $display("FAIL async_clear got=%b want=00000", {out_a, done_a, busy_a});
        else passes++;
        #1 rst_a = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if ({out_a, done_a, busy_a} !== {exp_out, exp_done, exp_busy})
                $display("FAIL async_rerun cyc=%0d got=%b want=%b", cyc, {out_a, done_a, busy_a}, {exp_out, exp_done, exp_busy});
            else passes++;
        end
    endtask

    task automatic test_sw_held();
        sw_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({out_a, done_a} !== 4'b0 || {out_a, done_a, busy_a} !== {exp_out, exp_done, exp_busy})
                $display("FAIL sw_held cyc=%0d got=%b want=%b", cyc, {out_a, done_a, busy_a}, {exp_out, exp_done, exp_busy});
            else passes++;
        end
        sw_a = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({out_a, done_a, busy_a} !== {exp_out, exp_done, exp_busy})
                $display("FAIL sw_release cyc=%0d got=%b want=%b", cyc, {out_a, done_a, busy_a}, {exp_out, exp_done, exp_busy});
            else passes++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            sw_a = ($urandom_range(0, 5) == 0);
            tick();
            checks++;
            if ({out_a, done_a, busy_a} !== {exp_out, exp_done, exp_busy})
                $display("FAIL random cyc=%0d got=%b want=%b", cyc, {out_a, done_a, busy_a}, {exp_out, exp_done, exp_busy});
            else passes++;
        end
        sw_a = 1'b0;
        for (int i = 0; i < 12; i++) tick();
    endtask

    task automatic test_rst_coincident();
        sw_a = 1'b1;
        @(posedge clk);
        rst_a = 1'b0;
        model_async_rst();
        #1;
        checks++;
        if ({out_a, done_a, busy_a} !== 5'b0) $display("FAIL coincident_clear got=%b want=00000", {out_a, done_a, busy_a});
        else passes++;
        @(negedge clk);
        for (int i = 0; i < 2; i++) tick();
        #2 rst_a = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if ({out_a, done_a, busy_a} !== {exp_out, exp_done, exp_busy})
                $display("FAIL coincident_sw cyc=%0d got=%b want=%b", cyc, {out_a, done_a, busy_a}, {exp_out, exp_done, exp_busy});
            else passes++;
        end
        sw_a = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({out_a, done_a, busy_a} !== {exp_out, exp_done, exp_busy})
                $display("FAIL coincident_release cyc=%0d got=%b want=%b", cyc, {out_a, done_a, busy_a}, {exp_out, exp_done, exp_busy});
            else passes++;
        end
    endtask

    task automatic test_param_sweep();
        logic [2:0] want;
        #2 rst_b = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            @(posedge clk);
            @(negedge clk);
            want = {(n >= 4) ? 1'b1 : 1'b0, (n >= 4) ? 1'b1 : 1'b0, (n == 3) ? 1'b1 : 1'b0};
            checks++;
            if ({out_b, done_b, busy_b} !== want)
                $display("FAIL sweep E%0d got=%b want=%b", n, {out_b, done_b, busy_b}, want);
            else passes++;
        end
    endtask

    initial begin
        rst_a = 1'b0; sw_a = 1'b0; rst_b = 1'b0; sw_b = 1'b0;
        model_eval();
        test_reset();
        test_power_on();
        test_sw_pulse();
        test_async_mid();
        test_sw_held();
        test_random();
        test_rst_coincident();
        test_param_sweep();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
